// File: rtl/rsa_seq_pkg.sv
// rtl/rsa_seq_pkg.sv - shared types and constants for the RSA UART sequencer
package rsa_seq_pkg;

    typedef enum logic [2:0] {
        S_QUERY_RX  = 3'd0,
        S_READ_RX   = 3'd1,
        S_START     = 3'd2,
        S_WAIT_CORE = 3'd3,
        S_QUERY_TX  = 3'd4,
        S_WRITE_TX  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        PH_N    = 2'd0,
        PH_E    = 2'd1,
        PH_DATA = 2'd2
    } phase_t;

    localparam int BYTES_IN  = 32;
    localparam int BYTES_OUT = 31;

endpackage

// File: rtl/rsa_uart_sequencer.sv
// rtl/rsa_uart_sequencer.sv - Avalon-MM master feeding key/ciphertext bytes from the UART to the RSA core
module rsa_uart_sequencer
    import rsa_seq_pkg::*;
#(
    parameter logic [4:0] RX_BASE     = 5'd0,
    parameter logic [4:0] TX_BASE     = 5'd4,
    parameter logic [4:0] STATUS_BASE = 5'd8,
    parameter int         RX_OK_BIT   = 7,
    parameter int         TX_OK_BIT   = 6
) (
    input  logic         i_clk,
    input  logic         i_rst,
    output logic [4:0]   avm_address,
    output logic         avm_read,
    input  logic [31:0]  avm_readdata,
    output logic         avm_write,
    output logic [31:0]  avm_writedata,
    input  logic         avm_waitrequest,
    output logic         o_core_start,
    output logic [255:0] o_core_a,
    output logic [255:0] o_core_e,
    output logic [255:0] o_core_n,
    input  logic [255:0] i_core_a_pow_e,
    input  logic         i_core_finished
);

    state_t       state_q, state_d;
    phase_t       phase_q, phase_d;
    logic [4:0]   byte_cnt_q, byte_cnt_d;
    logic [255:0] n_q, n_d, e_q, e_d, a_q, a_d;
    logic [247:0] out_sr_q, out_sr_d;
    logic [4:0]   addr_q, addr_d;
    logic         read_q, read_d, write_q, write_d;
    logic [7:0]   wdata_q, wdata_d;

    logic       xfer_done;
    logic [7:0] rx_byte;
    logic       unused_bits;

    assign xfer_done   = (read_q | write_q) & ~avm_waitrequest;
    assign rx_byte     = avm_readdata[7:0];
    // The result's top byte is never transmitted; the modulus is below 2^248.
    assign unused_bits = ^{avm_readdata[31:8], i_core_a_pow_e[255:248]};

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        byte_cnt_d = byte_cnt_q;
        n_d        = n_q;
        e_d        = e_q;
        a_d        = a_q;
        out_sr_d   = out_sr_q;
        addr_d     = addr_q;
        read_d     = read_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        case (state_q)
            S_QUERY_RX: begin
                if (xfer_done && avm_readdata[RX_OK_BIT]) begin
                    state_d = S_READ_RX;
                    addr_d  = RX_BASE;
                end
            end
            S_READ_RX: begin
                if (xfer_done) begin
                    case (phase_q)
                        PH_N:    n_d = {n_q[247:0], rx_byte};
                        PH_E:    e_d = {e_q[247:0], rx_byte};
                        PH_DATA: a_d = {a_q[247:0], rx_byte};
                        default: ;
                    endcase
                    state_d = S_QUERY_RX;
                    addr_d  = STATUS_BASE;
                    if (byte_cnt_q == 5'(BYTES_IN - 1)) begin
                        byte_cnt_d = '0;
                        case (phase_q)
                            PH_N:    phase_d = PH_E;
                            PH_E:    phase_d = PH_DATA;
                            default: begin
                                state_d = S_START;
                                read_d  = 1'b0;
                            end
                        endcase
                    end else begin
                        byte_cnt_d = byte_cnt_q + 5'd1;
                    end
                end
            end
            S_START: state_d = S_WAIT_CORE;
            S_WAIT_CORE: begin
                if (i_core_finished) begin
                    out_sr_d = i_core_a_pow_e[247:0];
                    state_d  = S_QUERY_TX;
                    read_d   = 1'b1;
                    addr_d   = STATUS_BASE;
                end
            end
            S_QUERY_TX: begin
                if (xfer_done && avm_readdata[TX_OK_BIT]) begin
                    state_d = S_WRITE_TX;
                    read_d  = 1'b0;
                    write_d = 1'b1;
                    addr_d  = TX_BASE;
                    wdata_d = out_sr_q[247:240];
                end
            end
            S_WRITE_TX: begin
                if (xfer_done) begin
                    out_sr_d = {out_sr_q[239:0], 8'h00};
                    write_d  = 1'b0;
                    read_d   = 1'b1;
                    addr_d   = STATUS_BASE;
                    if (byte_cnt_q == 5'(BYTES_OUT - 1)) begin
                        byte_cnt_d = '0;
                        state_d    = S_QUERY_RX;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 5'd1;
                        state_d    = S_QUERY_TX;
                    end
                end
            end
            default: begin
                state_d = S_QUERY_RX;
                read_d  = 1'b1;
                write_d = 1'b0;
                addr_d  = STATUS_BASE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_QUERY_RX;
            phase_q    <= PH_N;
            byte_cnt_q <= '0;
            n_q        <= '0;
            e_q        <= '0;
            a_q        <= '0;
            out_sr_q   <= '0;
            addr_q     <= STATUS_BASE;
            read_q     <= 1'b1;
            write_q    <= 1'b0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            byte_cnt_q <= byte_cnt_d;
            n_q        <= n_d;
            e_q        <= e_d;
            a_q        <= a_d;
            out_sr_q   <= out_sr_d;
            addr_q     <= addr_d;
            read_q     <= read_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
        end
    end

    assign avm_address   = addr_q;
    assign avm_read      = read_q;
    assign avm_write     = write_q;
    assign avm_writedata = {24'h000000, wdata_q};
    assign o_core_start  = (state_q == S_START);
    assign o_core_n      = n_q;
    assign o_core_e      = e_q;
    assign o_core_a      = a_q;

endmodule

// File: tb/tb_rsa_uart_sequencer.sv
// tb/tb_rsa_uart_sequencer.sv - directed bench with UART slave and core models
module tb_rsa_uart_sequencer;

    logic         i_clk;
    logic         i_rst;
    logic [4:0]   avm_address;
    logic         avm_read;
    logic [31:0]  avm_readdata;
    logic         avm_write;
    logic [31:0]  avm_writedata;
    logic         avm_waitrequest;
    logic         o_core_start;
    logic [255:0] o_core_a, o_core_e, o_core_n;
    logic [255:0] i_core_a_pow_e;
    logic         i_core_finished;

    rsa_uart_sequencer dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
        .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
        .o_core_start(o_core_start), .o_core_a(o_core_a), .o_core_e(o_core_e), .o_core_n(o_core_n),
        .i_core_a_pow_e(i_core_a_pow_e), .i_core_finished(i_core_finished)
    );

    localparam int CORE_LAT = 1000;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q[$];
    logic [7:0] tx_log[$];
    logic       rx_en = 1'b0;
    int wait_cycles = 0, tx_busy_polls = 0;
    int stall_cnt = 0, tx_poll_cnt = 0;
    logic last_tx_ok = 1'b0;
    int stab_viol = 0, both_cnt = 0, early_write = 0, bad_addr = 0, wd_hi = 0, rx_empty_read = 0;
    int rx_read_cnt = 0;
    logic [4:0]  sv_addr;
    logic        sv_rd, sv_wr;
    logic [31:0] sv_wd;

    int start_cnt = 0, start_rx = 0, core_cd = 0;
    logic [255:0] start_a, core_result;
    logic core_pending = 1'b0, fin_hold = 1'b0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // UART slave: decides stall/complete at negedge so the next posedge sees it
    initial begin
        avm_waitrequest = 1'b0;
        avm_readdata    = 32'h0;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                avm_waitrequest = 1'b0;
                avm_readdata    = 32'h0;
                stall_cnt       = 0;
            end else begin
                if (avm_read && avm_write) both_cnt++;
                if (avm_read || avm_write) begin
                    if (stall_cnt > 0 && (avm_address !== sv_addr || avm_read !== sv_rd ||
                                          avm_write !== sv_wr || avm_writedata !== sv_wd))
                        stab_viol++;
                    if (stall_cnt < wait_cycles) begin
                        avm_waitrequest = 1'b1;
                        sv_addr = avm_address; sv_rd = avm_read; sv_wr = avm_write; sv_wd = avm_writedata;
                        stall_cnt++;
                    end else begin
                        avm_waitrequest = 1'b0;
                        stall_cnt = 0;
                        if (avm_read && avm_address == 5'd8) begin
                            last_tx_ok = (tx_poll_cnt >= tx_busy_polls);
                            if (!last_tx_ok) tx_poll_cnt++;
                            avm_readdata = {24'hA5A5A5, rx_en && rx_q.size() > 0, last_tx_ok, 6'h15};
                        end else if (avm_read && avm_address == 5'd0) begin
                            if (rx_q.size() > 0) avm_readdata = {24'h5A5A5A, rx_q.pop_front()};
                            else begin rx_empty_read++; avm_readdata = 32'hFFFF_FF00; end
                            rx_read_cnt++;
                            tx_poll_cnt = 0;
                        end else if (avm_write && avm_address == 5'd4) begin
                            if (!last_tx_ok) early_write++;
                            if (avm_writedata[31:8] != 24'h0) wd_hi++;
                            tx_log.push_back(avm_writedata[7:0]);
                            tx_poll_cnt = 0;
                            last_tx_ok  = 1'b0;
                        end else begin
                            bad_addr++;
                        end
                    end
                end else begin
                    avm_waitrequest = 1'b0;
                    stall_cnt = 0;
                end
            end
        end
    end

    // Core model: fixed latency, returns the bench-chosen result; ignores i_rst on purpose
    initial begin
        i_core_finished = 1'b0;
        i_core_a_pow_e  = '0;
        core_result     = '0;
        forever begin
            @(negedge i_clk);
            if (fin_hold) begin
                i_core_finished = 1'b0;
                fin_hold = 1'b0;
            end
            if (o_core_start) begin
                start_cnt++;
                start_a = o_core_a;
                start_rx = rx_read_cnt;
                core_pending = 1'b1;
                core_cd = CORE_LAT;
            end else if (core_pending) begin
                core_cd--;
                if (core_cd == 0) begin
                    i_core_finished = 1'b1;
                    i_core_a_pow_e  = core_result;
                    core_pending = 1'b0;
                    fin_hold = 1'b1;
                end
            end
        end
    end

    task automatic push_block(input logic [7:0] last);
        for (int i = 0; i < 31; i++) rx_q.push_back(8'h00);
        rx_q.push_back(last);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (avm_read !== 1'b1 || avm_address !== 5'd8 || avm_write !== 1'b0 || o_core_start !== 1'b0) begin
            errors++;
            $display("FAIL %s_bus: read=%b addr=%0d write=%b start=%b, required 1/8/0/0",
                     tag, avm_read, avm_address, avm_write, o_core_start);
        end
        checks++;
        if (o_core_n !== '0 || o_core_e !== '0 || o_core_a !== '0) begin
            errors++;
            $display("FAIL %s_regs: n=%0h e=%0h a=%0h, required 0", tag, o_core_n, o_core_e, o_core_a);
        end
    endtask

    task automatic test_reset();
        int bad;
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        check_reset_outputs("reset");
        i_rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge i_clk);
            if (avm_read !== 1'b1 || avm_address !== 5'd8 || avm_write !== 1'b0 || o_core_start !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || rx_read_cnt != 0) begin
            errors++;
            $display("FAIL idle_poll: bad_cycles=%0d rx_reads=%0d, required 0 and 0", bad, rx_read_cnt);
        end
    endtask

    task automatic test_key_load();
        push_block(8'h8F);
        push_block(8'h07);
        rx_en = 1'b1;
        for (int i = 0; i < 5000 && rx_read_cnt < 64; i++) @(negedge i_clk);
        repeat (10) @(negedge i_clk);
        checks++;
        if (rx_read_cnt != 64) begin
            errors++;
            $display("FAIL key_reads: got %0d, required 64", rx_read_cnt);
        end
        checks++;
        if (o_core_n !== 256'd143 || o_core_e !== 256'd7) begin
            errors++;
            $display("FAIL key_regs: n=%0d e=%0d, required 143 and 7", o_core_n, o_core_e);
        end
        checks++;
        if (start_cnt != 0 || o_core_a !== '0) begin
            errors++;
            $display("FAIL key_nostart: starts=%0d a=%0d, required 0 and 0", start_cnt, o_core_a);
        end
    endtask

    task automatic test_block(input string tag, input logic [7:0] a_byte, input logic [255:0] result,
                              input logic [7:0] last_out, input int wc, input int polls);
        int s0, r0, bad_bytes;
        logic [7:0] exp_b;
        wait_cycles = wc;
        tx_busy_polls = polls;
        core_result = result;
        tx_log.delete();
        s0 = start_cnt;
        r0 = rx_read_cnt;
        stab_viol = 0; both_cnt = 0; early_write = 0; bad_addr = 0; wd_hi = 0; rx_empty_read = 0;
        push_block(a_byte);
        for (int i = 0; i < 20000 && tx_log.size() < 31; i++) @(negedge i_clk);
        repeat (20) @(negedge i_clk);
        checks++;
        if (start_cnt != s0 + 1 || start_a !== {248'h0, a_byte}) begin
            errors++;
            $display("FAIL %s_start: pulses=%0d a=%0d, required 1 and %0d", tag, start_cnt - s0, start_a, a_byte);
        end
        checks++;
        if (rx_read_cnt != r0 + 32 || rx_empty_read != 0) begin
            errors++;
            $display("FAIL %s_rxcount: reads=%0d empty=%0d, required 32 and 0", tag, rx_read_cnt - r0, rx_empty_read);
        end
        checks++;
        if (tx_log.size() != 31) begin
            errors++;
            $display("FAIL %s_txcount: got %0d writes, required 31", tag, tx_log.size());
        end else begin
            bad_bytes = 0;
            for (int i = 0; i < 31; i++) begin
                exp_b = (i == 30) ? last_out : 8'h00;
                if (tx_log[i] !== exp_b) begin
                    bad_bytes++;
                    $display("FAIL %s_txbyte%0d: got %02h, required %02h", tag, i, tx_log[i], exp_b);
                end
            end
            checks++;
            if (bad_bytes != 0) errors++;
        end
        checks++;
        if (stab_viol != 0 || both_cnt != 0 || bad_addr != 0 || wd_hi != 0) begin
            errors++;
            $display("FAIL %s_bus: unstable=%0d rd_and_wr=%0d bad_addr=%0d wdata_hi=%0d, required all 0",
                     tag, stab_viol, both_cnt, bad_addr, wd_hi);
        end
        checks++;
        if (early_write != 0) begin
            errors++;
            $display("FAIL %s_early_write: got %0d, required 0", tag, early_write);
        end
    endtask

    task automatic test_reset_mid_run();
        int s0, r0;
        wait_cycles = 0;
        tx_busy_polls = 0;
        core_result = 256'd128;
        tx_log.delete();
        s0 = start_cnt;
        push_block(8'h02);
        for (int i = 0; i < 5000 && start_cnt == s0; i++) @(negedge i_clk);
        repeat (10) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        check_reset_outputs("midreset");
        i_rst = 1'b0;
        s0 = start_cnt;
        repeat (1200) @(negedge i_clk);
        checks++;
        if (tx_log.size() != 0 || start_cnt != s0 || avm_read !== 1'b1 || avm_address !== 5'd8) begin
            errors++;
            $display("FAIL stale_finish: writes=%0d starts=%0d read=%b addr=%0d, required 0/0/1/8",
                     tx_log.size(), start_cnt - s0, avm_read, avm_address);
        end
        r0 = rx_read_cnt;
        push_block(8'h8F);
        push_block(8'h07);
        core_result = 256'd42;
        push_block(8'h03);
        for (int i = 0; i < 20000 && tx_log.size() < 31; i++) @(negedge i_clk);
        repeat (20) @(negedge i_clk);
        checks++;
        if (start_cnt != s0 + 1 || start_rx - r0 != 96) begin
            errors++;
            $display("FAIL reload_start: starts=%0d reads_before_start=%0d, required 1 and 96",
                     start_cnt - s0, start_rx - r0);
        end
        checks++;
        if (o_core_n !== 256'd143 || o_core_e !== 256'd7 || start_a !== 256'd3) begin
            errors++;
            $display("FAIL reload_regs: n=%0d e=%0d a=%0d, required 143/7/3", o_core_n, o_core_e, start_a);
        end
        checks++;
        if (tx_log.size() != 31 || tx_log[tx_log.size() - 1] !== 8'h2A) begin
            errors++;
            $display("FAIL reload_result: writes=%0d, required 31 ending in 2a", tx_log.size());
        end
    endtask

    initial begin
        i_rst = 1'b1;
        test_reset();
        test_key_load();
        test_block("blk_a2", 8'h02, 256'd128, 8'h80, 0, 0);
        test_block("blk_wait", 8'h02, 256'd128, 8'h80, 5, 0);
        test_block("blk_busy_a3", 8'h03, 256'd42, 8'h2A, 0, 20);
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rsa_uart_sequencer.md
Name: rsa_uart_sequencer

Overview:
- Avalon-MM master that sequences the 256-bit RSA modular-exponentiation core over the RS232 UART.
- After reset it receives the key: 32 bytes of N, then 32 bytes of E.
- It then loops forever: receive a 32-byte ciphertext block, start the core, wait for the result, transmit the 31-byte plaintext.
- It sits between the Qsys RS232 IP and the core; it is the only agent that drives the core's start.

Parameters:
- RX_BASE, 5'd0, UART RX data register address
- TX_BASE, 5'd4, UART TX data register address
- STATUS_BASE, 5'd8, UART status register address
- RX_OK_BIT, 7, status bit set when an RX byte is available
- TX_OK_BIT, 6, status bit set when TX can accept a byte

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; reset i_rst, synchronous, active-high; clock i_clk
- avm_address  out  5  Avalon address
- avm_read  out  1  Avalon read request
- avm_readdata  in  32  Avalon read data; bits [7:0] are used
- avm_write  out  1  Avalon write request
- avm_writedata  out  32  Avalon write data; bits [31:8] are always 0
- avm_waitrequest  in  1  Avalon stall
- o_core_start  out  1  one-cycle start pulse to the core
- o_core_a  out  256  ciphertext to the core
- o_core_e  out  256  exponent to the core
- o_core_n  out  256  modulus to the core
- i_core_a_pow_e  in  256  core result
- i_core_finished  in  1  core done pulse

Behaviour:
- Reset (synchronous, i_rst high at a clock edge):
  - state = S_QUERY_RX, phase = PH_N, byte_cnt = 0.
  - n, e, a and the output shift register are cleared to 0.
  - avm_read = 1, avm_address = STATUS_BASE, avm_write = 0, o_core_start = 0.
  - Reset mid-operation aborts everything, including a pending core run; the key must be reloaded.
- Avalon rules:
  - address, read, write and writedata stay stable while avm_waitrequest = 1.
  - A transfer completes on the first edge where the request is high and avm_waitrequest = 0.
  - read and write are never asserted together.
- Phases:
  - PH_N: 32 bytes into n.
  - PH_E: 32 bytes into e.
  - PH_DATA: 32 bytes into a.
- States:
  - S_QUERY_RX: read STATUS.
    - On completion with readdata[RX_OK_BIT] = 1, go to S_READ_RX with address = RX_BASE.
    - Otherwise re-issue the status read.
  - S_READ_RX: read RX.
    - On completion, shift the byte into the LSB of the phase register: reg = {reg[247:0], byte}, so the first byte received is the MSB. Increment byte_cnt.
    - When byte_cnt reaches 31 (32nd byte): wrap byte_cnt to 0 and advance the phase, PH_N -> PH_E -> PH_DATA. Go to S_QUERY_RX, except after the 32nd PH_DATA byte, when the next state is S_START.
    - Otherwise go back to S_QUERY_RX.
  - S_START: assert o_core_start for exactly 1 cycle, then S_WAIT_CORE.
  - S_WAIT_CORE: avm_read = avm_write = 0.
    - On i_core_finished = 1, capture i_core_a_pow_e into out_sr and go to S_QUERY_TX.
    - Wait indefinitely; there is no timeout.
  - S_QUERY_TX: read STATUS.
    - If bit TX_OK_BIT = 1, go to S_WRITE_TX with address = TX_BASE and writedata = out_sr[247:240].
    - Otherwise re-issue the status read.
  - S_WRITE_TX: write one byte.
    - On completion: out_sr <<= 8, increment byte_cnt.
    - After the 31st byte (byte_cnt = 30), clear byte_cnt, stay in PH_DATA and go to S_QUERY_RX for the next block.
    - Otherwise go to S_QUERY_TX.
- Core outputs: o_core_n, o_core_e and o_core_a are driven directly from the n, e and a registers. They are stable from S_START until the core finishes, because a is not written outside S_READ_RX.
- Output bytes: result bit 255..248 is never sent, since plaintext < N < 2^248 by protocol. Bytes are sent MSB first.
- i_core_finished outside S_WAIT_CORE is ignored.
- avm_readdata bits [31:8] are ignored.

Decomposition:
- Package rsa_seq_pkg:
  - state enum (S_QUERY_RX, S_READ_RX, S_START, S_WAIT_CORE, S_QUERY_TX, S_WRITE_TX)
  - phase enum (PH_N, PH_E, PH_DATA)
  - constants BYTES_IN = 32 and BYTES_OUT = 31
- Single module, no sub-module. The core is instantiated by the parent alongside this block, not inside it.

Test Plan:
- Reset, then status reads always 0 -> avm_read stays 1 at STATUS_BASE; RX_BASE is never addressed; o_core_start stays 0.
- Key load: N = 143 (31 zero bytes, then 0x8F) and E = 7 -> after 64 RX reads, o_core_n = 143 and o_core_e = 7; no start pulse yet.
- Block A = 2: 31 zero bytes then 0x02 -> a single o_core_start pulse with o_core_a = 2. The core model returns 128 after 1000 cycles; TX writes are 30 bytes of 0x00 then 0x80.
- waitrequest held high for 5 cycles on every transfer -> address, read, write and data are stable; each byte is counted exactly once; the result matches the previous case.
- TX_OK low for 20 status polls before each write -> no write until the bit is set; 31 writes total. A second block A = 3 then gives 3^7 mod 143 = 42, sent as 0x2A last.
- i_rst asserted during S_WAIT_CORE -> the next cycle shows reset outputs; a later i_core_finished is ignored; the full key is required again.
